// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter for NM masters onto one data-memory port,
// with held grants, a one-cycle turnaround gap and sticky timeout/protocol error flags.
module data_mem_arbiter #(
    parameter int NM = 2,
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int HOLD_MAX = 16,
    localparam int OW = $clog2(NM)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NM-1:0]    req,
    input  logic [NM-1:0]    cs,
    input  logic [NM*AW-1:0] addr,
    input  logic [NM*DW-1:0] wdata,
    input  logic [NM*2-1:0]  wdm,
    input  logic [NM*2-1:0]  rdm,
    output logic [NM-1:0]    grt,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic             m_cs,
    output logic [AW-1:0]    m_addr,
    output logic [DW-1:0]    m_wdata,
    output logic [1:0]       m_wdm,
    output logic [1:0]       m_rdm,
    output logic             to_err,
    output logic             prot_err
);
    localparam int HW = $clog2(HOLD_MAX + 2);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t state, state_nx;
    logic [OW-1:0] ptr, pick, off;
    logic [OW:0] sum;
    logic [NM-1:0] rot;
    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] addr_a [NM];
    logic [DW-1:0] wdata_a [NM];
    logic [1:0] wdm_a [NM];
    logic [1:0] rdm_a [NM];
    logic sel;

    for (genvar g = 0; g < NM; g++) begin : g_split
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*DW +: DW];
        assign wdm_a[g]   = wdm[g*2 +: 2];
        assign rdm_a[g]   = rdm[g*2 +: 2];
    end

    // Rotate so bit 0 is the master at ptr; lowest set bit is the winner.
    always_comb begin
        rot = NM'({req, req} >> ptr);
        off = '0;
        for (int k = NM - 1; k >= 0; k--)
            if (rot[k]) off = OW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        pick = OW'(sum >= (OW+1)'(NM) ? sum - (OW+1)'(NM) : sum);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? GRANT : IDLE;
            GRANT:   state_nx = req[owner] ? GRANT : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            grt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            to_err   <= 1'b0;
            prot_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (|(cs & ~grt)) prot_err <= 1'b1;
            if (state == IDLE && |req) begin
                grt      <= NM'(1) << pick;
                owner    <= pick;
                hold_cnt <= '0;
            end
            if (state == GRANT) begin
                if (hold_cnt < HW'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
                if (HOLD_MAX != 0 && hold_cnt + 1'b1 >= HW'(HOLD_MAX)) to_err <= 1'b1;
                if (!req[owner]) begin
                    grt <= '0;
                    ptr <= owner == OW'(NM - 1) ? '0 : owner + 1'b1;
                end
            end
        end
    end

    // Memory port is quiet unless the owner is granted and selecting.
    assign busy    = state == GRANT;
    assign sel     = busy & cs[owner];
    assign m_cs    = sel;
    assign m_addr  = sel ? addr_a[owner] : '0;
    assign m_wdata = sel ? wdata_a[owner] : '0;
    assign m_wdm   = sel ? wdm_a[owner] : '0;
    assign m_rdm   = sel ? rdm_a[owner] : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter against a
// cycle-level behavioural model; a second instance with HOLD_MAX=0 shares the inputs.
module tb_data_mem_arbiter;
    localparam int NM = 2, AW = 16, DW = 32, HM = 4, OW = $clog2(NM);
    logic Clk = 1'b0, Rst = 1'b1;
    logic [NM-1:0] req = '0, cs = '0;
    logic [NM*AW-1:0] addr = '0;
    logic [NM*DW-1:0] wdata = '0;
    logic [NM*2-1:0] wdm = '0, rdm = '0;
    logic [NM-1:0] grt, grt0;
    logic [OW-1:0] owner, owner0;
    logic busy, m_cs, to_err, prot_err, busy0, m_cs0, to_err0, prot_err0;
    logic [AW-1:0] m_addr, m_addr0;
    logic [DW-1:0] m_wdata, m_wdata0;
    logic [1:0] m_wdm, m_rdm, m_wdm0, m_rdm0;
    int n_chk = 0, n_fail = 0;
    int phase, e_owner, e_ptr, e_held;
    bit e_to, e_prot, e_sel;
    logic [NM-1:0] e_grt;

    data_mem_arbiter #(.NM(NM), .AW(AW), .DW(DW), .HOLD_MAX(HM)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .cs(cs), .addr(addr), .wdata(wdata),
        .wdm(wdm), .rdm(rdm), .grt(grt), .owner(owner), .busy(busy), .m_cs(m_cs),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wdm(m_wdm), .m_rdm(m_rdm),
        .to_err(to_err), .prot_err(prot_err));

    data_mem_arbiter #(.NM(NM), .AW(AW), .DW(DW), .HOLD_MAX(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .req(req), .cs(cs), .addr(addr), .wdata(wdata),
        .wdm(wdm), .rdm(rdm), .grt(grt0), .owner(owner0), .busy(busy0), .m_cs(m_cs0),
        .m_addr(m_addr0), .m_wdata(m_wdata0), .m_wdm(m_wdm0), .m_rdm(m_rdm0),
        .to_err(to_err0), .prot_err(prot_err0));

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = 0; e_owner = 0; e_ptr = 0; e_held = 0; e_to = 0; e_prot = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Model: phase 0 idle, 1 granted, 2 turnaround. Checked mid-cycle, then advanced
    // with the inputs that the next rising edge will see.
    always @(negedge Clk) begin
        if (Rst) model_reset();
        e_grt = phase == 1 ? NM'(1) << e_owner : '0;
        e_sel = phase == 1 && cs[e_owner];
        chk("grt", grt, e_grt);
        chk("owner", owner, e_owner);
        chk("busy", busy, phase == 1);
        chk("m_cs", m_cs, e_sel);
        chk("m_addr", m_addr, e_sel ? addr[e_owner*AW +: AW] : 0);
        chk("m_wdata", m_wdata, e_sel ? wdata[e_owner*DW +: DW] : 0);
        chk("m_wdm", m_wdm, e_sel ? wdm[e_owner*2 +: 2] : 0);
        chk("m_rdm", m_rdm, e_sel ? rdm[e_owner*2 +: 2] : 0);
        chk("to_err", to_err, e_to);
        chk("prot_err", prot_err, e_prot);
        chk("grt_nohold", grt0, e_grt);
        chk("to_err_nohold", to_err0, 1'b0);
        if (!Rst) begin
            if (|(cs & ~e_grt)) e_prot = 1;
            if (phase == 0) begin
                for (int k = 0; k < NM; k++)
                    if (req[(e_ptr + k) % NM]) begin
                        e_owner = (e_ptr + k) % NM;
                        phase = 1;
                        e_held = 0;
                        break;
                    end
            end else if (phase == 1) begin
                e_held++;
                if (HM != 0 && e_held >= HM) e_to = 1;
                if (!req[e_owner]) begin
                    phase = 2;
                    e_ptr = (e_owner + 1) % NM;
                end
            end else phase = 0;
        end
    end

    initial begin
        tick(2);
        Rst = 1'b0;
        #1;
        chk("rst_grt", grt, 2'b00);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {to_err, prot_err}, 2'b00);
        // Alternation with two simultaneous requesters.
        req = 2'b11;
        tick(); chk("alt_grt0", grt, 2'b01);
        req = 2'b10;
        tick(); chk("alt_gap1", grt, 2'b00);
        tick(); chk("alt_gap2", grt, 2'b00);
        tick(); chk("alt_grt1", grt, 2'b10); chk("alt_owner1", owner, 1);
        req = 2'b01;
        tick(); chk("alt_gap3", grt, 2'b00);
        tick(2); chk("alt_grt0b", grt, 2'b01);
        req = 2'b00;
        tick(3);
        // Owner 0 access while master 1 drives unrelated values without cs.
        req = 2'b01;
        addr = {16'h1234, 16'h0040};
        wdata = {32'hCAFEF00D, 32'hDEADBEEF};
        wdm = {2'd2, 2'd3};
        rdm = {2'd1, 2'd0};
        tick(); chk("mux_grt", grt, 2'b01);
        cs = 2'b01;
        #1;
        chk("mux_cs", m_cs, 1);
        chk("mux_addr", m_addr, 16'h0040);
        chk("mux_wdata", m_wdata, 32'hDEADBEEF);
        chk("mux_wdm", m_wdm, 2'd3);
        chk("mux_rdm", m_rdm, 2'd0);
        tick();
        cs = 2'b00; req = 2'b00;
        #1; chk("mux_off", {m_cs, m_addr}, 0);
        tick(3);
        // One-cycle request pulse.
        req = 2'b01;
        tick(); req = 2'b00;
        chk("pulse_grt", grt, 2'b01); chk("pulse_mcs", m_cs, 0);
        tick(); chk("pulse_gap", grt, 2'b00);
        tick(2); chk("pulse_idle", {grt, busy}, 0);
        // Asynchronous reset while master 1 owns the port.
        req = 2'b10;
        tick(); chk("rstg_grt", grt, 2'b10);
        Rst = 1'b1;
        #1;
        chk("rstg_grt0", grt, 2'b00); chk("rstg_owner", owner, 0); chk("rstg_busy", busy, 0);
        tick(); Rst = 1'b0;
        tick(); chk("rstg_regrant", grt, 2'b10);
        req = 2'b00;
        tick(3);
        // Grant held past HOLD_MAX.
        req = 2'b01;
        tick();
        tick(3); chk("hold_3", to_err, 0);
        tick(); chk("hold_4", to_err, 1); chk("hold_grt", grt, 2'b01);
        tick(6); chk("hold_keep", grt, 2'b01); chk("hold_sticky", to_err, 1);
        chk("hold_disabled", to_err0, 0);
        req = 2'b00;
        tick(3); chk("hold_after", to_err, 1);
        Rst = 1'b1; #1; chk("hold_clear", to_err, 0);
        tick(); Rst = 1'b0;
        tick();
        // Chip select without a grant.
        cs = 2'b10;
        tick(); chk("prot_set", prot_err, 1); chk("prot_mcs", m_cs, 0);
        cs = 2'b00;
        tick(2); chk("prot_sticky", prot_err, 1);
        Rst = 1'b1; #1; chk("prot_clear", prot_err, 0);
        tick(); Rst = 1'b0;
        // Randomized traffic with occasional resets and rare protocol violations.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (Rst) Rst = 1'b0;
            else if ($urandom_range(249) == 0) Rst = 1'b1;
            for (int i = 0; i < NM; i++) begin
                if (req[i] && grt[i] && $urandom_range(3) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
                addr[i*AW +: AW] = AW'($urandom);
                wdata[i*DW +: DW] = $urandom;
                wdm[i*2 +: 2] = 2'($urandom);
                rdm[i*2 +: 2] = 2'($urandom);
            end
            cs = grt & NM'($urandom);
            if ($urandom_range(99) == 0) cs[$urandom_range(NM - 1)] = 1'b1;
        end
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
